// File: rtl/liang_pkg.sv
// rtl/liang_pkg.sv - shared uop, function-unit and writeback types
// Purpose: common definitions for the integer issue/ALU slice.
// Contents: XLEN, fu_op_e / fu_func_e encodings, uop_info_t, wb_entry_t.
package liang_pkg;

  localparam int XLEN      = 32;
  // Writeback entry fields are sized for the widest configuration; users
  // truncate to their own TAG_W / source-index width.
  localparam int TAG_MAX_W = 16;
  localparam int SRC_MAX_W = 8;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_BRANCH = 2'd1,
    OP_JAL    = 2'd2,
    OP_JALR   = 2'd3
  } fu_op_e;

  typedef enum logic [4:0] {
    FN_ADD  = 5'd0,
    FN_ADDI = 5'd1,
    FN_SUB  = 5'd2,
    FN_AND  = 5'd3,
    FN_OR   = 5'd4,
    FN_XOR  = 5'd5,
    FN_SLL  = 5'd6,
    FN_SRL  = 5'd7,
    FN_SRA  = 5'd8,
    FN_SLT  = 5'd9,
    FN_SLTU = 5'd10,
    FN_BEQ  = 5'd11,
    FN_BNE  = 5'd12,
    FN_BLT  = 5'd13,
    FN_BGE  = 5'd14,
    FN_BLTU = 5'd15,
    FN_BGEU = 5'd16
  } fu_func_e;

  typedef struct packed {
    fu_op_e            fu_op;
    fu_func_e          fu_func;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } uop_info_t;

  typedef struct packed {
    logic [XLEN-1:0]      res;
    logic                 we;
    logic [TAG_MAX_W-1:0] tag;
    logic [SRC_MAX_W-1:0] src;
  } wb_entry_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU with branch resolution
// Purpose: computes the ALU result and whether a control transfer is taken.
// Ports:
//   uop_i  : fu_op, fu_func, pc, imm
//   rs1_i  : first operand
//   rs2_i  : second operand (imm replaces it for ADDI)
//   res_o  : result; pc+4 for JAL/JALR; 0 for BRANCH
//   jump_o : 1 for JAL/JALR, branch condition for BRANCH, else 0
module alu
  import liang_pkg::*;
(
  input  uop_info_t        uop_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  output logic [XLEN-1:0]  res_o,
  output logic             jump_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] opb;
  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            br_cond;
  logic [XLEN-1:0] alu_res;

  assign opb   = (uop_i.fu_func == FN_ADDI) ? uop_i.imm : rs2_i;
  assign shamt = opb[SH_W-1:0];
  assign lt_s  = $signed(rs1_i) < $signed(opb);
  assign lt_u  = rs1_i < opb;
  assign eq    = rs1_i == opb;

  always_comb begin
    alu_res = '0;
    case (uop_i.fu_func)
      FN_ADD, FN_ADDI: alu_res = rs1_i + opb;
      FN_SUB:          alu_res = rs1_i - opb;
      FN_AND:          alu_res = rs1_i & opb;
      FN_OR:           alu_res = rs1_i | opb;
      FN_XOR:          alu_res = rs1_i ^ opb;
      FN_SLL:          alu_res = rs1_i << shamt;
      FN_SRL:          alu_res = rs1_i >> shamt;
      FN_SRA:          alu_res = XLEN'($signed(rs1_i) >>> shamt);
      FN_SLT:          alu_res = {{(XLEN-1){1'b0}}, lt_s};
      FN_SLTU:         alu_res = {{(XLEN-1){1'b0}}, lt_u};
      default:         alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (uop_i.fu_func)
      FN_BEQ:  br_cond = eq;
      FN_BNE:  br_cond = !eq;
      FN_BLT:  br_cond = lt_s;
      FN_BGE:  br_cond = !lt_s;
      FN_BLTU: br_cond = lt_u;
      FN_BGEU: br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    res_o  = alu_res;
    jump_o = 1'b0;
    case (uop_i.fu_op)
      OP_BRANCH: begin
        res_o  = '0;
        jump_o = br_cond;
      end
      OP_JAL, OP_JALR: begin
        res_o  = uop_i.pc + XLEN'(4);
        jump_o = 1'b1;
      end
      default: begin
        res_o  = alu_res;
        jump_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_arb.sv
// rtl/alu_issue_arb.sv - round-robin issue arbiter in front of a shared ALU
// Purpose: grants one of NREQ requesters per cycle into a single ALU, holds
//   the result in one writeback register with backpressure, and pulses a
//   fetch redirect for taken branches, JAL and JALR.
// Ports:
//   clk_i, rst_n_i           : clock, async active-low reset
//   req_valid_i/req_ready_o  : per-requester handshake (ready is one-hot)
//   req_uop_i/rs1/rs2/tag    : per-requester uop, operands and dest tag
//   flush_i                  : synchronous kill of writeback and redirect
//   wb_valid_o/wb_ready_i    : writeback handshake
//   wb_res_o/we/tag/src      : writeback payload
//   redirect_valid_o/pc_o    : one-cycle redirect pulse and target
module alu_issue_arb
  import liang_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int TAG_W = 4,
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  uop_info_t [NREQ-1:0]        req_uop_i,
  input  logic [NREQ-1:0][XLEN-1:0]   req_rs1_i,
  input  logic [NREQ-1:0][XLEN-1:0]   req_rs2_i,
  input  logic [NREQ-1:0][TAG_W-1:0]  req_tag_i,
  input  logic                        flush_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [XLEN-1:0]             wb_res_o,
  output logic                        wb_we_o,
  output logic [TAG_W-1:0]            wb_tag_o,
  output logic [SRC_W-1:0]            wb_src_o,
  output logic                        redirect_valid_o,
  output logic [XLEN-1:0]             redirect_pc_o
);

  // First valid requester at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [SRC_W:0] rr_pick(input logic [NREQ-1:0]  valid,
                                             input logic [SRC_W-1:0] ptr);
    logic             found;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = SRC_W'((int'(ptr) + k) % NREQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_next;
  logic [SRC_W-1:0] grant;
  logic             grant_hit;
  logic             can_accept;
  logic             hs;

  uop_info_t        sel_uop;
  logic [XLEN-1:0]  sel_rs1;
  logic [XLEN-1:0]  sel_rs2;
  logic [TAG_W-1:0] sel_tag;
  logic [XLEN-1:0]  alu_res;
  logic             alu_jump;

  logic [XLEN-1:0]  tgt_base;
  logic [XLEN-1:0]  tgt_sum;
  logic [XLEN-1:0]  tgt_pc;
  logic             ctrl_taken;

  wb_entry_t        wb_d;
  wb_entry_t        wb_q;
  logic             wb_valid_q;
  logic             redir_valid_q;
  logic [XLEN-1:0]  redir_pc_q;

  // Ready is also gated by reset so every output reads 0 while held in reset.
  assign can_accept = rst_n_i && !flush_i && !redir_valid_q &&
                      (!wb_valid_q || wb_ready_i);

  assign {grant_hit, grant} = rr_pick(req_valid_i, rr_ptr);
  assign req_ready_o = (can_accept && grant_hit) ? (NREQ'(1) << grant) : '0;
  assign hs          = can_accept && grant_hit;
  assign rr_next     = SRC_W'((int'(grant) + 1) % NREQ);

  assign sel_uop = req_uop_i[grant];
  assign sel_rs1 = req_rs1_i[grant];
  assign sel_rs2 = req_rs2_i[grant];
  assign sel_tag = req_tag_i[grant];

  alu u_alu (
    .uop_i  (sel_uop),
    .rs1_i  (sel_rs1),
    .rs2_i  (sel_rs2),
    .res_o  (alu_res),
    .jump_o (alu_jump)
  );

  // Target adder is separate from the ALU so the link value and the target
  // are both available in the same cycle.
  assign tgt_base   = (sel_uop.fu_op == OP_JALR) ? sel_rs1 : sel_uop.pc;
  assign tgt_sum    = tgt_base + sel_uop.imm;
  assign tgt_pc     = (sel_uop.fu_op == OP_JALR) ? {tgt_sum[XLEN-1:1], 1'b0}
                                                 : tgt_sum;
  assign ctrl_taken = (sel_uop.fu_op == OP_JAL) || (sel_uop.fu_op == OP_JALR) ||
                      ((sel_uop.fu_op == OP_BRANCH) && alu_jump);

  always_comb begin
    wb_d     = '0;
    wb_d.res = alu_res;
    wb_d.we  = (sel_uop.fu_op != OP_BRANCH);
    wb_d.tag = TAG_MAX_W'(sel_tag);
    wb_d.src = SRC_MAX_W'(grant);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_q    <= 1'b0;
      wb_q          <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      rr_ptr        <= '0;
    end else if (flush_i) begin
      wb_valid_q    <= 1'b0;
      redir_valid_q <= 1'b0;
    end else begin
      redir_valid_q <= hs && ctrl_taken;
      if (hs) begin
        wb_valid_q <= 1'b1;
        wb_q       <= wb_d;
        rr_ptr     <= rr_next;
        if (ctrl_taken) begin
          redir_pc_q <= tgt_pc;
        end
      end else if (wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid_o       = wb_valid_q;
  assign wb_res_o         = wb_q.res;
  assign wb_we_o          = wb_q.we;
  assign wb_tag_o         = TAG_W'(wb_q.tag);
  assign wb_src_o         = SRC_W'(wb_q.src);
  assign redirect_valid_o = redir_valid_q;
  assign redirect_pc_o    = redir_pc_q;

endmodule
